memory_scheduler: RTL

MEMORY_SCHEDULER -- requirements
Module: memory_scheduler

---
 rtl/memory_scheduler.sv | 106 ++++++++++
 1 files changed

// File: rtl/memory_scheduler.sv
// Arbitrates an instruction port and a data port onto one memory bus, with bounded data priority.
// Optional macro SCHED_POSTED_WRITE_EN acknowledges data writes in their grant cycle.
module memory_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       grant_d;
  logic       grant_i;
  logic       posted_grant;
  logic       posted_busy;
  logic       d_done;

  // Data wins ties until it has starved a waiting instruction request LIMIT times.
  assign grant_d = (state == IDLE) && dmem_valid && (!imem_valid || (starve_cnt < LIMIT));
  assign grant_i = (state == IDLE) && imem_valid && !grant_d;

`ifdef SCHED_POSTED_WRITE_EN
  assign posted_grant = grant_d && (dmem_wstrb != 4'd0) && !rst;
  assign posted_busy  = (memory_wstrb != 4'd0);
`else
  assign posted_grant = 1'b0;
  assign posted_busy  = 1'b0;
`endif

  // Completion pulses are dropped if the owner abandoned its request.
  assign imem_ready = (state == IBUSY) && memory_ready && imem_valid;
  assign d_done     = (state == DBUSY) && memory_ready && dmem_valid && !posted_busy;
  assign dmem_ready = posted_grant || d_done;
  assign imem_rdata = imem_ready ? memory_rdata : 32'd0;
  assign dmem_rdata = d_done ? memory_rdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= 4'd0;
      memory_valid <= 1'b0;
      memory_instr <= 1'b0;
      memory_addr  <= 32'd0;
      memory_wdata <= 32'd0;
      memory_wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= IBUSY;
            starve_cnt   <= 4'd0;
            memory_valid <= 1'b1;
            memory_instr <= 1'b1;
            memory_addr  <= imem_addr;
            memory_wdata <= 32'd0;
            memory_wstrb <= 4'd0;
          end else if (grant_d) begin
            state        <= DBUSY;
            memory_valid <= 1'b1;
            memory_instr <= 1'b0;
            memory_addr  <= dmem_addr;
            memory_wdata <= dmem_wdata;
            memory_wstrb <= dmem_wstrb;
            if (!imem_valid) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt < LIMIT) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        default: begin
          // A latched access always runs to completion on the bus.
          if (memory_ready) begin
            state        <= IDLE;
            memory_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
